// File: rtl/imem_rr_arbiter.sv
// Shared instruction-memory arbiter: grants one CPU fetch per cycle and returns
// the read data to that CPU MEM_LAT cycles later through a tagged pipeline.
module imem_rr_arbiter #(
    parameter int nCPUs    = 3,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 1,
    parameter int ARB_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [nCPUs-1:0]      req,
    input  logic [nCPUs*AW-1:0]   addr,
    output logic [nCPUs-1:0]      gnt,
    output logic [nCPUs-1:0]      rvalid,
    output logic [nCPUs*DW-1:0]   rdata,
    output logic                  mem_en,
    output logic [AW-1:0]         mem_addr,
    input  logic [DW-1:0]         mem_rdata
);

    localparam int IW = (nCPUs > 1) ? $clog2(nCPUs) : 1;

    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       win;
    logic [IW:0]         scan;
    logic                found;
    logic [AW-1:0]       maddr_q;
    logic [MEM_LAT-1:0]  vld_q;
    logic [IW-1:0]       id_q [MEM_LAT];
    logic [nCPUs*DW-1:0] rdata_q;

    // Walk the request vector from ptr (round-robin) or from 0 (fixed priority).
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int i = 0; i < nCPUs; i++) begin
            if (ARB_MODE == 0) begin
                scan = {1'b0, ptr_q} + (IW+1)'(i);
                if (scan >= (IW+1)'(nCPUs)) begin
                    scan = scan - (IW+1)'(nCPUs);
                end
            end else begin
                scan = (IW+1)'(i);
            end
            if (!found && req[scan[IW-1:0]]) begin
                found = 1'b1;
                win   = scan[IW-1:0];
            end
        end
    end

    assign mem_en   = rst & found;
    assign mem_addr = mem_en ? addr[win*AW +: AW] : maddr_q;

    always_comb begin
        gnt = '0;
        if (mem_en) begin
            gnt[win] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (ARB_MODE == 0 && mem_en) begin
            ptr_d = (win == IW'(nCPUs - 1)) ? '0 : win + 1'b1;
        end
    end

    always_comb begin
        rvalid = '0;
        if (vld_q[MEM_LAT-1]) begin
            rvalid[id_q[MEM_LAT-1]] = 1'b1;
        end
    end

    // The responding lane shows mem_rdata directly; every other lane keeps its last value.
    always_comb begin
        rdata = rdata_q;
        for (int i = 0; i < nCPUs; i++) begin
            if (rvalid[i]) begin
                rdata[i*DW +: DW] = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            maddr_q <= '0;
            vld_q   <= '0;
            rdata_q <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                id_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            maddr_q  <= mem_addr;
            rdata_q  <= rdata;
            vld_q[0] <= mem_en;
            id_q[0]  <= win;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_imem_rr_arbiter.sv
// Randomized bench for imem_rr_arbiter: three instances (RR lat 1, RR lat 3,
// fixed-priority lat 2) checked against a queue-based reference model.
module tb_imem_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int EW = 72;  // {due cycle[31:0], cpu[7:0], data[31:0]}

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_w       [3];
    logic [N*AW-1:0] addr_w      [3];
    logic [N-1:0]    gnt_w       [3];
    logic [N-1:0]    rvalid_w    [3];
    logic [N*DW-1:0] rdata_w     [3];
    logic            mem_en_w    [3];
    logic [AW-1:0]   mem_addr_w  [3];
    logic [DW-1:0]   mem_rdata_w [3];

    imem_rr_arbiter #(.nCPUs(N), .AW(AW), .DW(DW), .MEM_LAT(1), .ARB_MODE(0)) u_rr_l1 (
        .clk(clk), .rst(rst), .req(req_w[0]), .addr(addr_w[0]), .gnt(gnt_w[0]),
        .rvalid(rvalid_w[0]), .rdata(rdata_w[0]), .mem_en(mem_en_w[0]),
        .mem_addr(mem_addr_w[0]), .mem_rdata(mem_rdata_w[0]));

    imem_rr_arbiter #(.nCPUs(N), .AW(AW), .DW(DW), .MEM_LAT(3), .ARB_MODE(0)) u_rr_l3 (
        .clk(clk), .rst(rst), .req(req_w[1]), .addr(addr_w[1]), .gnt(gnt_w[1]),
        .rvalid(rvalid_w[1]), .rdata(rdata_w[1]), .mem_en(mem_en_w[1]),
        .mem_addr(mem_addr_w[1]), .mem_rdata(mem_rdata_w[1]));

    imem_rr_arbiter #(.nCPUs(N), .AW(AW), .DW(DW), .MEM_LAT(2), .ARB_MODE(1)) u_fp_l2 (
        .clk(clk), .rst(rst), .req(req_w[2]), .addr(addr_w[2]), .gnt(gnt_w[2]),
        .rvalid(rvalid_w[2]), .rdata(rdata_w[2]), .mem_en(mem_en_w[2]),
        .mem_addr(mem_addr_w[2]), .mem_rdata(mem_rdata_w[2]));

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 2;
    endfunction

    function automatic int mode_of(int k);
        return (k == 2) ? 1 : 0;
    endfunction

    // Memory model: word-addressed table read with a per-instance latency pipe.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] mpipe [3][3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            mpipe[k][0] <= mem_en_w[k] ? mem[mem_addr_w[k][9:2]] : $urandom();
            mpipe[k][1] <= mpipe[k][0];
            mpipe[k][2] <= mpipe[k][1];
        end
    end
    assign mem_rdata_w[0] = mpipe[0][0];
    assign mem_rdata_w[1] = mpipe[1][2];
    assign mem_rdata_w[2] = mpipe[2][1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: actual=%0h required=%0h", nm, k, cyc, act, exp);
        end
    endtask

    // Scoreboard queues, one per instance.
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q2[$];

    function automatic int q_size(int k);
        case (k)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic void q_push(int k, logic [EW-1:0] e);
        case (k)
            0:       exp_q0.push_back(e);
            1:       exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endfunction

    function automatic logic [EW-1:0] q_pop(int k);
        case (k)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    function automatic logic [EW-1:0] q_front(int k);
        case (k)
            0:       return exp_q0[0];
            1:       return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    // Reference model state.
    int            ptr_m       [3];
    int            win_m       [3];
    logic [AW-1:0] last_addr_m [3];
    logic [DW-1:0] last_rd_m   [3][3];

    function automatic int pick(logic [N-1:0] r, int p, int mode);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (mode == 1) ? i : (p + i) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        for (int k = 0; k < 3; k++) begin
            ptr_m[k]       = 0;
            win_m[k]       = -1;
            last_addr_m[k] = '0;
            for (int c = 0; c < N; c++) last_rd_m[k][c] = '0;
        end
    endtask

    // One cycle: inputs are already applied; check grant side, queue responses.
    task automatic step();
        int            w [3];
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        for (int k = 0; k < 3; k++) begin
            w[k] = rst ? pick(req_w[k], ptr_m[k], mode_of(k)) : -1;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            eg = '0;
            ea = last_addr_m[k];
            if (w[k] >= 0) begin
                eg[w[k]] = 1'b1;
                ea = addr_w[k][w[k]*AW +: AW];
            end
            chk("gnt", k, 128'(gnt_w[k]), 128'(eg));
            chk("mem_en", k, 128'(mem_en_w[k]), 128'(w[k] >= 0));
            chk("mem_addr", k, 128'(mem_addr_w[k]), 128'(ea));
            if (w[k] >= 0) begin
                q_push(k, {32'(cyc + lat_of(k)), 8'(w[k]), mem[ea[9:2]]});
                last_addr_m[k] = ea;
                if (mode_of(k) == 0) ptr_m[k] = (w[k] + 1) % N;
            end
            win_m[k] = w[k];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [N-1:0] r);
        for (int k = 0; k < 3; k++) req_w[k] = r;
    endtask

    // Requests stay up until granted; a granted CPU may drop or re-request.
    task automatic random_inputs();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < N; c++) begin
                if (req_w[k][c]) begin
                    if (win_m[k] == c && $urandom_range(0, 1) == 0) req_w[k][c] = 1'b0;
                end else if ($urandom_range(0, 9) < 4) begin
                    req_w[k][c] = 1'b1;
                    addr_w[k][c*AW +: AW] = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
                end
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a response.
    always @(negedge clk) begin : monitor
        logic [EW-1:0]   e;
        logic [N-1:0]    er;
        logic [N*DW-1:0] erd;
        int              c;
        for (int k = 0; k < 3; k++) begin
            if (rvalid_w[k] != '0) begin
                if (q_size(k) == 0) begin
                    chk("rvalid_spurious", k, 128'(rvalid_w[k]), 128'(0));
                end else begin
                    e  = q_pop(k);
                    c  = int'(e[39:32]);
                    er = '0;
                    er[c] = 1'b1;
                    chk("rvalid_cpu", k, 128'(rvalid_w[k]), 128'(er));
                    chk("rvalid_cycle", k, 128'(cyc), 128'(e[71:40]));
                    last_rd_m[k][c] = e[31:0];
                end
            end else if (q_size(k) > 0) begin
                e = q_front(k);
                if (e[71:40] == 32'(cyc)) begin
                    e = q_pop(k);
                    chk("rvalid_missing", k, 128'(rvalid_w[k]), 128'(1) << e[39:32]);
                end
            end
            erd = {last_rd_m[k][2], last_rd_m[k][1], last_rd_m[k][0]};
            chk("rdata", k, 128'(rdata_w[k]), 128'(erd));
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        model_reset();
        set_all(3'b111);
        for (int k = 0; k < 3; k++) addr_w[k] = {32'h30, 32'h4, 32'h0};
        @(posedge clk);
        #1;

        // Reset held with all requests up: nothing granted or returned.
        repeat (4) step();

        // Release: first grant 001 everywhere, then RR rotates; FP sticks to CPU 1 on 110.
        rst = 1'b1;
        step();
        req_w[2] = 3'b110;
        repeat (4) step();

        // Sparse: a lone top request then a lone bottom request.
        set_all(3'b100);
        step();
        set_all(3'b001);
        step();
        set_all(3'b000);
        repeat (2) step();

        for (int n = 0; n < 400; n++) begin
            random_inputs();
            step();
        end

        // Reset while responses are in flight: they must be discarded.
        set_all(3'b111);
        repeat (2) step();
        rst = 1'b0;
        model_reset();
        repeat (3) step();
        rst = 1'b1;
        set_all(3'b000);
        repeat (5) step();
        set_all(3'b111);
        repeat (3) step();

        set_all(3'b000);
        repeat (6) step();
        for (int k = 0; k < 3; k++) chk("undelivered", k, 128'(q_size(k)), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
